// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 4-digit 7-segment scan driver.
//   - state_t    : scan FSM encoding (ST_IDLE, ST_SCAN)
//   - NUM_DIGITS : number of multiplexed digits
//   - SEG_OFF    : raw (active-high) all-segments-off pattern
//   - SEG_TABLE  : hex nibble -> segment pattern, bit order {g,f,e,d,c,b,a}
package seg7_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_OFF = 7'b0;

    // Entry n is the pattern for nibble n (rightmost entry is nibble 0).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E D C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // B A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

endpackage

// File: rtl/decode_7seg_hex.sv
// decode_7seg_hex: combinational hex nibble to 7-segment decoder.
// Ports:
//   hex         in  4  nibble to display
//   active_high in  1  1 = lit segment driven high, 0 = lit segment driven low
//   seg         out 7  segment pattern {g,f,e,d,c,b,a}
module decode_7seg_hex
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       active_high,
    output logic [6:0] seg
);

    assign seg = active_high ? SEG_TABLE[hex] : ~SEG_TABLE[hex];

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed driver for a 4-digit 7-segment display.
// Snapshots value once per frame, blanks the start of every digit slot to
// avoid ghosting, and gates each slot with a 16-level brightness window.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
// Ports:
//   clk         in  1   system clock
//   reset_n     in  1   asynchronous active-low reset
//   enable      in  1   1 = scan, 0 = idle with display dark
//   value       in  16  hex value; nibble n shown on digit n
//   brightness  in  4   on-window level 0..15
//   seg_pol     in  1   segment polarity (1 = active-high)
//   dig_pol     in  1   digit-enable polarity (1 = active-high)
//   segments    out 7   shared segment lines {g,f,e,d,c,b,a}
//   digit_en    out 4   one-hot digit enable
//   frame_start out 1   one-cycle pulse when a frame snapshot is taken
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | display dark, counters held at 0, waiting for enable
// ST_SCAN | prescale/digit running, current slot driven from shadow
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int DIVIDER_BITS = 10,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic [3:0]  brightness,
    input  logic        seg_pol,
    input  logic        dig_pol,
    output logic [6:0]  segments,
    output logic [3:0]  digit_en,
    output logic        frame_start
);

    localparam int DW = $clog2(NUM_DIGITS);
    localparam logic [DIVIDER_BITS-1:0] BLANK_P = DIVIDER_BITS'(BLANK_CYCLES);
    localparam logic [DW-1:0]           LAST_DIGIT = DW'(NUM_DIGITS - 1);

    state_t                  state, state_nxt;
    logic [DIVIDER_BITS-1:0] prescale, prescale_nxt;
    logic [DW-1:0]           digit, digit_nxt;
    logic [15:0]             shadow, shadow_nxt;
    logic [6:0]              seg_q, seg_nxt;
    logic [3:0]              dig_q, dig_nxt;
    logic                    frame_start_nxt;

    logic [3:0] nibble;
    logic [6:0] dec_seg;
    logic       slot_on;
    logic       lz_blank;

    assign nibble = shadow[{digit, 2'b00} +: 4];

    decode_7seg_hex u_dec (
        .hex         (nibble),
        .active_high (1'b1),
        .seg         (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Digit n is dark when it and every more significant nibble are zero;
    // digit 0 is never suppressed so zero still shows a single "0".
    always_comb begin
        lz_blank = 1'b0;
        case (digit)
            2'd3:    lz_blank = (shadow[15:12] == 4'h0);
            2'd2:    lz_blank = (shadow[15:8] == 8'h00);
            2'd1:    lz_blank = (shadow[15:4] == 12'h000);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    // Blanking window first, then the brightness window on the top 4 bits.
    assign slot_on = (prescale >= BLANK_P)
                  && (prescale[DIVIDER_BITS-1 -: 4] <= brightness)
                  && !lz_blank;

    always_comb begin
        state_nxt       = state;
        prescale_nxt    = prescale;
        digit_nxt       = digit;
        shadow_nxt      = shadow;
        seg_nxt         = SEG_OFF;
        dig_nxt         = 4'b0000;
        frame_start_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                prescale_nxt = '0;
                digit_nxt    = '0;
                if (enable) begin
                    state_nxt       = ST_SCAN;
                    shadow_nxt      = value;
                    frame_start_nxt = 1'b1;
                end
            end
            ST_SCAN: begin
                if (!enable) begin
                    state_nxt    = ST_IDLE;
                    prescale_nxt = '0;
                    digit_nxt    = '0;
                end else begin
                    prescale_nxt = prescale + 1'b1;
                    if (prescale == '1) begin
                        digit_nxt = digit + 1'b1;
                        if (digit == LAST_DIGIT) begin
                            shadow_nxt      = value;
                            frame_start_nxt = 1'b1;
                        end
                    end
                    if (slot_on) begin
                        seg_nxt = dec_seg;
                        dig_nxt = 4'b0001 << digit;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            prescale    <= '0;
            digit       <= '0;
            shadow      <= 16'h0000;
            seg_q       <= SEG_OFF;
            dig_q       <= 4'b0000;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            prescale    <= prescale_nxt;
            digit       <= digit_nxt;
            shadow      <= shadow_nxt;
            seg_q       <= seg_nxt;
            dig_q       <= dig_nxt;
            frame_start <= frame_start_nxt;
        end
    end

    assign segments = seg_pol ? seg_q : ~seg_q;
    assign digit_en = dig_pol ? dig_q : ~dig_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: directed bench for seg7_scan_mux with a short slot
// (DIVIDER_BITS=6 -> 64-cycle slots, 256-cycle frames, BLANK_CYCLES=2).
// Observed word per check is {frame_start, digit_en, segments}.
module tb_seg7_scan_mux;

    localparam int DB    = 6;
    localparam int SLOT  = 1 << DB;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] value;
    logic [3:0]  brightness;
    logic        seg_pol;
    logic        dig_pol;
    logic [6:0]  segments;
    logic [3:0]  digit_en;
    logic        frame_start;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seg7_scan_mux #(
        .DIVIDER_BITS (DB),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .value       (value),
        .brightness  (brightness),
        .seg_pol     (seg_pol),
        .dig_pol     (dig_pol),
        .segments    (segments),
        .digit_en    (digit_en),
        .frame_start (frame_start)
    );

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got fs/dig/seg=%h expected %h", tag, got, exp);
        end
    endtask

    // One rising edge, then return on the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Checks one full slot; i is the prescale value the edge evaluated.
    task automatic check_slot(input string tag, input logic [3:0] d_on, input logic [6:0] s_on,
                              input logic inv, input int lo, input int hi, input logic fs_end);
        logic [11:0] e;
        logic        fs;
        for (int i = 0; i < SLOT; i++) begin
            cyc();
            fs = fs_end && (i == SLOT - 1);
            if (i >= lo && i <= hi)
                e = inv ? {fs, ~d_on, ~s_on} : {fs, d_on, s_on};
            else
                e = inv ? {fs, 4'hF, 7'h7F} : {fs, 4'h0, 7'h00};
            check($sformatf("%s[%0d]", tag, i), {frame_start, digit_en, segments}, e);
        end
    endtask

    task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3,
                               input logic inv, input int lo, input int hi);
        check_slot({tag, "_d0"}, 4'b0001, s0, inv, lo, hi, 1'b0);
        check_slot({tag, "_d1"}, 4'b0010, s1, inv, lo, hi, 1'b0);
        check_slot({tag, "_d2"}, 4'b0100, s2, inv, lo, hi, 1'b0);
        check_slot({tag, "_d3"}, 4'b1000, s3, inv, lo, hi, 1'b1);
    endtask

    initial begin
        reset_n    = 1'b0;
        enable     = 1'b0;
        value      = 16'h1234;
        brightness = 4'd15;
        seg_pol    = 1'b1;
        dig_pol    = 1'b1;

        #12;
        check("rst_off_pos", {frame_start, digit_en, segments}, 12'h000);
        seg_pol = 1'b0;
        dig_pol = 1'b0;
        #1;
        check("rst_off_neg", {frame_start, digit_en, segments}, {1'b0, 4'hF, 7'h7F});
        seg_pol = 1'b1;
        dig_pol = 1'b1;

        @(negedge clk);
        reset_n = 1'b1;
        cyc();
        check("idle_dark", {frame_start, digit_en, segments}, 12'h000);

        // Frame 1: full brightness, 1234 -> digits 4,3,2,1.
        enable = 1'b1;
        cyc();
        check("fs_first", {frame_start, digit_en, segments}, {1'b1, 4'h0, 7'h00});
        check_frame("f1", 7'h66, 7'h4F, 7'h5B, 7'h06, 1'b0, 2, 63);

        // Frame 2: brightness 3 -> on for prescale 2..15.
        brightness = 4'd3;
        check_frame("f2_b3", 7'h66, 7'h4F, 7'h5B, 7'h06, 1'b0, 2, 15);

        // Frame 3: brightness 0 -> on for prescale 2..3; value changes after digit 0.
        brightness = 4'd0;
        check_slot("f3_d0", 4'b0001, 7'h66, 1'b0, 2, 3, 1'b0);
        value = 16'hABCD;
        check_slot("f3_d1", 4'b0010, 7'h4F, 1'b0, 2, 3, 1'b0);
        check_slot("f3_d2", 4'b0100, 7'h5B, 1'b0, 2, 3, 1'b0);
        check_slot("f3_d3", 4'b1000, 7'h06, 1'b0, 2, 3, 1'b1);

        // Frame 4: new snapshot ABCD -> D,C,B,A.
        brightness = 4'd15;
        value      = 16'h1234;
        check_frame("f4_abcd", 7'h5E, 7'h39, 7'h7C, 7'h77, 1'b0, 2, 63);

        // Frame 5: both polarities active-low.
        seg_pol = 1'b0;
        dig_pol = 1'b0;
        check_frame("f5_inv", 7'h66, 7'h4F, 7'h5B, 7'h06, 1'b1, 2, 63);
        seg_pol = 1'b1;
        dig_pol = 1'b1;

        // Async reset mid-slot, outputs must drop before the next edge.
        repeat (20) cyc();
        check("mid_slot_on", {frame_start, digit_en, segments}, {1'b0, 4'b0001, 7'h66});
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst", {frame_start, digit_en, segments}, 12'h000);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
        check("fs_after_rst", {frame_start, digit_en, segments}, {1'b1, 4'h0, 7'h00});
        check_slot("r_d0", 4'b0001, 7'h66, 1'b0, 2, 63, 1'b0);

        // Drop enable mid-slot: dark on the next edge, no frame pulse.
        repeat (5) cyc();
        check("r_d1_on", {frame_start, digit_en, segments}, {1'b0, 4'b0010, 7'h4F});
        enable = 1'b0;
        cyc();
        check("disable", {frame_start, digit_en, segments}, 12'h000);
        repeat (3) cyc();
        check("idle_again", {frame_start, digit_en, segments}, 12'h000);

        value  = 16'h0040;
        enable = 1'b1;
        cyc();
        check("fs_0040", {frame_start, digit_en, segments}, {1'b1, 4'h0, 7'h00});
`ifdef LEADING_ZERO_BLANK_EN
        check_slot("lz_d0", 4'b0001, 7'h3F, 1'b0, 2, 63, 1'b0);
        check_slot("lz_d1", 4'b0010, 7'h66, 1'b0, 2, 63, 1'b0);
        value = 16'h0000;
        check_slot("lz_d2", 4'b0100, 7'h00, 1'b0, SLOT, 0, 1'b0);
        check_slot("lz_d3", 4'b1000, 7'h00, 1'b0, SLOT, 0, 1'b1);
        check_slot("lz0_d0", 4'b0001, 7'h3F, 1'b0, 2, 63, 1'b0);
        check_slot("lz0_d1", 4'b0010, 7'h00, 1'b0, SLOT, 0, 1'b0);
        check_slot("lz0_d2", 4'b0100, 7'h00, 1'b0, SLOT, 0, 1'b0);
        check_slot("lz0_d3", 4'b1000, 7'h00, 1'b0, SLOT, 0, 1'b1);
`else
        check_slot("nz_d0", 4'b0001, 7'h3F, 1'b0, 2, 63, 1'b0);
        check_slot("nz_d1", 4'b0010, 7'h66, 1'b0, 2, 63, 1'b0);
        value = 16'h0000;
        check_slot("nz_d2", 4'b0100, 7'h3F, 1'b0, 2, 63, 1'b0);
        check_slot("nz_d3", 4'b1000, 7'h3F, 1'b0, 2, 63, 1'b1);
        check_frame("nz0", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0, 2, 63);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
